// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Leading-zero blanking lives behind HEX_SCAN_LZB_EN; lzb_dark() is the helper for that build.
package hex_scan_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_e;

  localparam int PWM_STEPS  = 16;
  localparam int NUM_DIGITS = 4;

  // A digit is a leading zero when it and every higher digit are zero; digit 0 never is.
  function automatic logic lzb_dark(input logic [15:0] snap, input logic [1:0] dig);
    logic dark;
    dark = (dig != 2'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(dig) && snap[4*k +: 4] != 4'h0) dark = 1'b0;
    end
    return dark;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to abcdefg segment pattern (active-high, a is the MSB).
module hex_to_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/tick_gen.sv
// Scan prescaler: tick is high for one cycle every CLK_DIV clocks; clr holds the count at 0.
module tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Timed 4-digit 7-segment scanner with blanking gap, 16-step PWM and per-frame data snapshot.
// Optional leading-zero blanking when HEX_SCAN_LZB_EN is defined.
//   IDLE  | scanning stopped, all anodes off
//   BLANK | anti-ghosting gap at the start of a digit slot
//   ON    | PWM window of the current digit (16 ticks)
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data,
  input  logic [3:0]  brightness,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic [1:0]  digit,
  output logic        frame_done
);

  localparam int CW = (BLANK_TICKS > PWM_STEPS) ? $clog2(BLANK_TICKS) : $clog2(PWM_STEPS);
  localparam state_e SLOT_START = (BLANK_TICKS == 0) ? ON : BLANK;

  state_e          state_q, state_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [15:0]     snap_q, snap_d;
  logic [3:0]      anodes_q, anodes_d;
  logic            fd_q, fd_d;
  logic            tick;
  logic            clr;
  logic [3:0]      nibble;

  assign clr = (state_q == IDLE);

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    digit_d  = digit_q;
    snap_d   = snap_q;
    fd_d     = 1'b0;
    anodes_d = 4'b0000;

    case (state_q)
      IDLE: begin
        if (enable) begin
          snap_d  = data;
          digit_d = 2'd0;
          tcnt_d  = '0;
          state_d = SLOT_START;
        end
      end
      BLANK: begin
        if (tick) begin
          if (tcnt_q == CW'(BLANK_TICKS - 1)) begin
            tcnt_d  = '0;
            state_d = ON;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      ON: begin
        if (tick) begin
          if (tcnt_q == CW'(PWM_STEPS - 1)) begin
            tcnt_d  = '0;
            state_d = SLOT_START;
            if (digit_q == 2'(NUM_DIGITS - 1)) begin
              fd_d    = 1'b1;
              snap_d  = data;
              digit_d = 2'd0;
            end else begin
              digit_d = digit_q + 2'd1;
            end
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      tcnt_d  = '0;
      digit_d = digit_q;
      snap_d  = snap_q;
      fd_d    = 1'b0;
    end

    // Anodes are registered, so they are derived from the next-state values.
    if (state_d == ON && tcnt_d <= CW'(brightness)) begin
      anodes_d = 4'b0001 << digit_d;
`ifdef HEX_SCAN_LZB_EN
      if (lzb_dark(snap_d, digit_d)) anodes_d = 4'b0000;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      digit_q  <= 2'd0;
      snap_q   <= 16'h0000;
      anodes_q <= 4'b0000;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      digit_q  <= digit_d;
      snap_q   <= snap_d;
      anodes_q <= anodes_d;
      fd_q     <= fd_d;
    end
  end

  assign nibble = snap_q[4*digit_q +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (segments)
  );

  assign anodes     = anodes_q;
  assign digit      = digit_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with CLK_DIV=2, BLANK_TICKS=1 (slot 34, frame 136 clocks).
module tb_hex_scan_ctrl;

  localparam int SLOT  = 34;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] data;
  logic [3:0]  brightness;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic [1:0]  digit;
  logic        frame_done;
  logic [13:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  bright;
    logic [15:0] shown;
    logic [15:0] next_data;
  } frame_vec_t;

  frame_vec_t vecs[5];

  localparam logic [13:0] RESET_VEC = {4'b0000, 2'd0, 7'b1111110, 1'b0};

  hex_scan_ctrl #(.CLK_DIV(2), .BLANK_TICKS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data       (data),
    .brightness (brightness),
    .anodes     (anodes),
    .segments   (segments),
    .digit      (digit),
    .frame_done (frame_done)
  );

  assign outs = {anodes, digit, segments, frame_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Expected {anodes, digit, segments, frame_done} at clock offset o within a frame.
  function automatic logic [13:0] expect_out(input int o, input int frame,
                                             input logic [3:0] b, input logic [15:0] shown);
    int s, p;
    logic lit;
    logic [3:0] an;
    logic [3:0] nib;
    s   = o / SLOT;
    p   = o % SLOT;
    lit = (p >= 2) && ((p - 2) < 2 * (int'(b) + 1));
`ifdef HEX_SCAN_LZB_EN
    if (s != 0 && (shown >> (4 * s)) == 16'h0000) lit = 1'b0;
`endif
    an  = lit ? (4'b0001 << s) : 4'b0000;
    nib = 4'((shown >> (4 * s)) & 16'h000F);
    return {an, 2'(s), seg_of(nib), (frame > 0 && o == 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step_check(input string name, input int o, input int frame,
                            input logic [3:0] b, input logic [15:0] shown);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_o%0d", name, o), 32'(outs), 32'(expect_out(o, frame, b, shown)));
  endtask

  initial begin
    vecs[0] = '{4'd15, 16'h12AF, 16'h3333};
    vecs[1] = '{4'd3,  16'h3333, 16'h0000};
    vecs[2] = '{4'd0,  16'h0000, 16'h0100};
    vecs[3] = '{4'd15, 16'h0100, 16'h5A5A};
    vecs[4] = '{4'd7,  16'h5A5A, 16'hC0DE};

    rst        = 1'b1;
    enable     = 1'b0;
    data       = 16'h12AF;
    brightness = 4'd15;
    repeat (2) @(negedge clk);
    check("reset", 32'(outs), 32'(RESET_VEC));
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(outs), 32'(RESET_VEC));

    // Frames driven from the table; data changes mid-frame must only show in the next frame.
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int o = 0; o < FRAME; o++) begin
        if (o == 0)  brightness = vecs[f].bright;
        if (o == 60) data = vecs[f].next_data;
        step_check($sformatf("frame%0d", f), o, f, vecs[f].bright, vecs[f].shown);
      end
    end

    // Run into the ON window of digit 2, then drop enable.
    for (int o = 0; o <= 80; o++) step_check("frame5", o, 5, 4'd7, 16'hC0DE);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("en_drop_dark", 32'({anodes, frame_done}), 32'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_stays_dark", 32'({anodes, frame_done}), 32'(0));

    // Re-enable: restart at digit 0 with a fresh snapshot.
    data   = 16'hBEEF;
    enable = 1'b1;
    for (int o = 0; o <= 45; o++) step_check("reen", o, 0, 4'd7, 16'hBEEF);
    check("pre_async_lit", 32'(anodes), 32'(4'b0010));

    // Asynchronous reset between edges.
    #1 rst = 1'b1;
    #1 check("async_rst", 32'(outs), 32'(RESET_VEC));
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(outs), 32'(RESET_VEC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
